// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI data-island scheduler and its helpers.
package hdmi_pkg;

  typedef enum logic [2:0] {
    PH_VIDEO    = 3'd0,
    PH_PREAMBLE = 3'd1,
    PH_LGUARD   = 3'd2,
    PH_ISLAND   = 3'd3,
    PH_TGUARD   = 3'd4
  } phase_e;

  localparam int unsigned PREAMBLE_LEN = 8;
  localparam int unsigned GUARD_LEN    = 2;
  localparam int unsigned PKT_LEN      = 32;

  localparam int unsigned REQ_AUDIO = 0;
  localparam int unsigned REQ_ACR   = 1;
  localparam int unsigned REQ_AVI   = 2;
  localparam int unsigned REQ_AIF   = 3;

  // Packets that fit in one island: pending count, capped, then trimmed to the blank budget.
  function automatic int unsigned island_pkts(int unsigned pending, int unsigned max_pkts,
                                              int unsigned budget, bit always_island);
    int unsigned n;
    int unsigned fit;
    n = (pending < max_pkts) ? pending : max_pkts;
    if (n == 0 && always_island) n = 1;
    if (budget < PREAMBLE_LEN + 2 * GUARD_LEN) begin
      fit = 0;
    end else begin
      fit = (budget - PREAMBLE_LEN - 2 * GUARD_LEN) / PKT_LEN;
    end
    if (n > fit) n = fit;
    return n;
  endfunction

endpackage

// File: rtl/hdmi_rr_arbiter.sv
// Combinational round-robin pick over the non-audio requesters, starting at ptr.
module hdmi_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PtrW = $clog2(NREQ)
) (
  input  logic [NREQ-1:1] req,
  input  logic [PtrW-1:0] ptr,
  output logic [NREQ-1:1] gnt,
  output logic            found
);

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    // First pass from the pointer upwards, second pass covers the wrap below it.
    for (int i = 1; i < int'(NREQ); i++) begin
      if (!found && req[i] && i >= int'(ptr)) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 1; i < int'(NREQ); i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Schedules data islands in horizontal blank and arbitrates packet sources per 32-cycle slot.
module hdmi_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned MAX_PKTS      = 3,
  parameter logic [10:0] HBLANK_BUDGET = 11'd140,
  parameter bit          ALWAYS_ISLAND = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            hsync,
  input  logic            de,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            pkt_load,
  output logic [1:0]      pkt_sel,
  output logic            pkt_null,
  output logic [2:0]      phase,
  output logic [4:0]      dib,
  output logic            overrun
);

  localparam int unsigned PtrW = $clog2(NREQ);

  typedef enum logic [2:0] {StIdle, StPre, StLGuard, StPkt, StTGuard, StDone} state_e;

  state_e          state_q;
  logic [4:0]      cnt_q;
  logic [7:0]      pkt_idx_q;
  logic [7:0]      pkts_q;
  logic [PtrW-1:0] ptr_q;
  logic [10:0]     h_q;

  int unsigned     plan_n;
  logic            plan_go;
  logic            last_tguard;
  logic            abort;
  logic            slot_start;

  logic [NREQ-1:1] arb_gnt;
  logic            arb_found;
  logic [NREQ-1:0] slot_gnt;
  logic [1:0]      slot_sel;
  logic            slot_null;
  logic [PtrW-1:0] slot_ptr;

  hdmi_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req  (req[NREQ-1:1]),
    .ptr  (ptr_q),
    .gnt  (arb_gnt),
    .found(arb_found)
  );

  always_comb begin
    plan_n = island_pkts(32'($countones(req)), MAX_PKTS, 32'(HBLANK_BUDGET), ALWAYS_ISLAND);
    plan_go = !hsync && (h_q == '0) && (plan_n != 0);
    last_tguard = (state_q == StTGuard) && (cnt_q == 5'(GUARD_LEN - 1));
    // An hsync rise on the final trailing-guard cycle lets the island finish cleanly.
    abort = (state_q inside {StPre, StLGuard, StPkt, StTGuard}) &&
            (de || (hsync && !last_tguard));
    slot_start = !abort &&
                 (((state_q == StLGuard) && (cnt_q == 5'(GUARD_LEN - 1))) ||
                  ((state_q == StPkt) && (cnt_q == 5'(PKT_LEN - 1)) &&
                   (pkt_idx_q + 8'd1 != pkts_q)));
  end

  always_comb begin
    slot_gnt  = '0;
    slot_sel  = '0;
    slot_null = 1'b0;
    slot_ptr  = ptr_q;
    if (req[REQ_AUDIO]) begin
      slot_gnt[REQ_AUDIO] = 1'b1;
    end else if (arb_found) begin
      slot_gnt = {arb_gnt, 1'b0};
      for (int i = 1; i < int'(NREQ); i++) begin
        if (arb_gnt[i]) begin
          slot_sel = 2'(i);
          slot_ptr = (i == int'(NREQ) - 1) ? PtrW'(REQ_ACR) : PtrW'(i + 1);
        end
      end
    end else begin
      slot_null = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pkt_idx_q <= '0;
      pkts_q    <= '0;
      ptr_q     <= PtrW'(REQ_ACR);
      h_q       <= '0;
      gnt       <= '0;
      pkt_load  <= 1'b0;
      pkt_sel   <= '0;
      pkt_null  <= 1'b0;
      phase     <= PH_VIDEO;
      dib       <= '0;
      overrun   <= 1'b0;
    end else begin
      h_q      <= hsync ? '0 : ((h_q == 11'h7FF) ? h_q : h_q + 11'd1);
      gnt      <= '0;
      pkt_load <= 1'b0;
      pkt_sel  <= '0;
      pkt_null <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
        phase   <= PH_VIDEO;
        dib     <= '0;
        cnt_q   <= '0;
        overrun <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (plan_go) begin
              state_q   <= StPre;
              phase     <= PH_PREAMBLE;
              cnt_q     <= '0;
              pkt_idx_q <= '0;
              pkts_q    <= 8'(plan_n);
            end
          end
          StPre: begin
            if (cnt_q == 5'(PREAMBLE_LEN - 1)) begin
              state_q <= StLGuard;
              phase   <= PH_LGUARD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          StLGuard: begin
            if (cnt_q == 5'(GUARD_LEN - 1)) begin
              state_q <= StPkt;
              phase   <= PH_ISLAND;
              cnt_q   <= '0;
              dib     <= '0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          StPkt: begin
            if (cnt_q == 5'(PKT_LEN - 1)) begin
              cnt_q <= '0;
              dib   <= '0;
              if (pkt_idx_q + 8'd1 == pkts_q) begin
                state_q <= StTGuard;
                phase   <= PH_TGUARD;
              end else begin
                pkt_idx_q <= pkt_idx_q + 8'd1;
              end
            end else begin
              cnt_q <= cnt_q + 5'd1;
              dib   <= cnt_q + 5'd1;
            end
          end
          StTGuard: begin
            if (last_tguard) begin
              state_q <= hsync ? StIdle : StDone;
              phase   <= PH_VIDEO;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          StDone: begin
            if (hsync) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
        if (slot_start) begin
          gnt      <= slot_gnt;
          pkt_load <= 1'b1;
          pkt_sel  <= slot_sel;
          pkt_null <= slot_null;
          ptr_q    <= slot_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for hdmi_island_scheduler: default, tight-budget and no-null-island instances.
module tb_hdmi_island_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       hsync;
  logic       de;
  logic [3:0] req;

  logic [3:0] gnt, gnt_b, gnt_n;
  logic       pkt_load, pkt_load_b, pkt_load_n;
  logic [1:0] pkt_sel, pkt_sel_b, pkt_sel_n;
  logic       pkt_null, pkt_null_b, pkt_null_n;
  logic [2:0] phase, phase_b, phase_n;
  logic [4:0] dib, dib_b, dib_n;
  logic       overrun, overrun_b, overrun_n;

  int n_cmp = 0;
  int n_bad = 0;
  int b_len, b_loads, n_len;

  always #5 clk = ~clk;

  hdmi_island_scheduler dut (
    .clk(clk), .resetn(resetn), .hsync(hsync), .de(de), .req(req),
    .gnt(gnt), .pkt_load(pkt_load), .pkt_sel(pkt_sel), .pkt_null(pkt_null),
    .phase(phase), .dib(dib), .overrun(overrun)
  );

  hdmi_island_scheduler #(.HBLANK_BUDGET(11'd50)) dut_b (
    .clk(clk), .resetn(resetn), .hsync(hsync), .de(de), .req(req),
    .gnt(gnt_b), .pkt_load(pkt_load_b), .pkt_sel(pkt_sel_b), .pkt_null(pkt_null_b),
    .phase(phase_b), .dib(dib_b), .overrun(overrun_b)
  );

  hdmi_island_scheduler #(.ALWAYS_ISLAND(1'b0)) dut_n (
    .clk(clk), .resetn(resetn), .hsync(hsync), .de(de), .req(req),
    .gnt(gnt_n), .pkt_load(pkt_load_n), .pkt_sel(pkt_sel_n), .pkt_null(pkt_null_n),
    .phase(phase_n), .dib(dib_n), .overrun(overrun_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One blanking line: hsync pulse, then 112 cycles of hsync low checked against a hand model.
  task automatic run_line(input string tag, input logic [3:0] req_v, input int n,
                          input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                          input bit nul, input bit drop_audio, input logic exp_ovr,
                          output int bl, output int bld, output int nl);
    int         eph, edib, k;
    logic       eload;
    logic [1:0] esel;
    logic [3:0] egnt;
    bl = 0; bld = 0; nl = 0;
    req   = req_v;
    hsync = 1'b1;
    repeat (4) step();
    hsync = 1'b0;
    for (int j = 0; j < 112; j++) begin
      step();
      if (j < 8) eph = 1;
      else if (j < 10) eph = 2;
      else if (j < 10 + 32 * n) eph = 3;
      else if (j < 12 + 32 * n) eph = 4;
      else eph = 0;
      edib  = (eph == 3) ? (j - 10) % 32 : 0;
      eload = (eph == 3) && (edib == 0);
      k     = (j - 10) / 32;
      esel  = (k == 0) ? s0 : ((k == 1) ? s1 : s2);
      egnt  = (eload && !nul) ? (4'd1 << esel) : 4'd0;
      chk($sformatf("%s phase j%0d", tag, j), 32'(phase), 32'(eph));
      chk($sformatf("%s dib j%0d", tag, j), 32'(dib), 32'(edib));
      chk($sformatf("%s load j%0d", tag, j), 32'(pkt_load), 32'(eload));
      chk($sformatf("%s gnt j%0d", tag, j), 32'(gnt), 32'(egnt));
      chk($sformatf("%s sel j%0d", tag, j), 32'(pkt_sel), eload ? 32'(esel) : 32'd0);
      chk($sformatf("%s null j%0d", tag, j), 32'(pkt_null), 32'(eload && nul));
      chk($sformatf("%s ovr j%0d", tag, j), 32'(overrun), 32'(exp_ovr));
      if (phase_b != 3'd0) bl++;
      if (pkt_load_b) bld++;
      if (phase_n != 3'd0) nl++;
      if (drop_audio && j == 10) req[0] = 1'b0;
    end
  endtask

  initial begin
    resetn = 1'b0;
    hsync  = 1'b1;
    de     = 1'b0;
    req    = 4'b0000;
    repeat (3) step();
    chk("rst phase", 32'(phase), 32'd0);
    chk("rst dib", 32'(dib), 32'd0);
    chk("rst gnt", 32'(gnt), 32'd0);
    chk("rst load", 32'(pkt_load), 32'd0);
    chk("rst ovr", 32'(overrun), 32'd0);
    resetn = 1'b1;
    step();

    run_line("aud", 4'b0001, 1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, b_len, b_loads, n_len);
    chk("aud b50 len", 32'(b_len), 32'd44);
    chk("aud noisl len", 32'(n_len), 32'd44);

    run_line("all", 4'b1111, 3, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, b_len, b_loads, n_len);
    chk("all b50 len", 32'(b_len), 32'd44);
    chk("all b50 loads", 32'(b_loads), 32'd1);

    run_line("rr1", 4'b1111, 3, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, b_len, b_loads, n_len);
    run_line("rr2", 4'b1111, 3, 2'd0, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0, b_len, b_loads, n_len);

    run_line("null", 4'b0000, 1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, b_len, b_loads, n_len);
    chk("null noisl len", 32'(n_len), 32'd0);

    // Abort: de rises while the fifth island cycle is on the outputs.
    req   = 4'b0001;
    hsync = 1'b1;
    repeat (4) step();
    hsync = 1'b0;
    for (int j = 0; j < 15; j++) step();
    chk("abt pre phase", 32'(phase), 32'd3);
    chk("abt pre dib", 32'(dib), 32'd4);
    chk("abt pre ovr", 32'(overrun), 32'd0);
    de = 1'b1;
    step();
    chk("abt phase", 32'(phase), 32'd0);
    chk("abt ovr", 32'(overrun), 32'd1);
    for (int j = 0; j < 40; j++) begin
      if (j == 3) de = 1'b0;
      step();
      chk($sformatf("abt idle phase %0d", j), 32'(phase), 32'd0);
      chk($sformatf("abt idle load %0d", j), 32'(pkt_load), 32'd0);
      chk($sformatf("abt sticky ovr %0d", j), 32'(overrun), 32'd1);
    end

    run_line("post", 4'b0001, 1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, b_len, b_loads, n_len);

    // Reset mid-packet at dib=17, then confirm the rr pointer restarted at 1.
    req   = 4'b1111;
    hsync = 1'b1;
    repeat (4) step();
    hsync = 1'b0;
    for (int j = 0; j < 28; j++) step();
    chk("mid dib", 32'(dib), 32'd17);
    resetn = 1'b0;
    #1;
    chk("mrst phase", 32'(phase), 32'd0);
    chk("mrst dib", 32'(dib), 32'd0);
    chk("mrst gnt", 32'(gnt), 32'd0);
    chk("mrst load", 32'(pkt_load), 32'd0);
    chk("mrst sel", 32'(pkt_sel), 32'd0);
    chk("mrst null", 32'(pkt_null), 32'd0);
    chk("mrst ovr", 32'(overrun), 32'd0);
    hsync = 1'b1;
    repeat (3) step();
    resetn = 1'b1;
    step();

    run_line("rst rr", 4'b1111, 3, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, b_len, b_loads, n_len);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
